// File: rtl/paddle_input_arbiter_if.sv
// rtl/paddle_input_arbiter_if.sv - control and command signals of the paddle input arbiter
interface paddle_input_arbiter_if #(
    parameter int PLAYERS = 2
);
    logic [1:0]           input_mode;
    logic [2*PLAYERS-1:0] btn_n;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic [PLAYERS-1:0]   paddle_up;
    logic [PLAYERS-1:0]   paddle_down;
    logic                 mode_settling;

    modport master (
        output input_mode, btn_n, rx_data, rx_valid,
        input  paddle_up, paddle_down, mode_settling
    );

    modport slave (
        input  input_mode, btn_n, rx_data, rx_valid,
        output paddle_up, paddle_down, mode_settling
    );
endinterface

// File: rtl/paddle_input_arbiter.sv
// rtl/paddle_input_arbiter.sv - button/keyboard paddle command arbiter with settle blanking and hold timers
module paddle_input_arbiter #(
    parameter int                   PLAYERS       = 2,
    parameter int                   HOLD_CYCLES   = 30000000,
    parameter int                   SETTLE_CYCLES = 1024,
    parameter logic [8*2*PLAYERS-1:0] KEY_MAP     = {"l", "o", "s", "w"},
    parameter logic [7:0]           STOP_KEY      = 8'h20
) (
    input  logic                  clk,
    input  logic                  rst,
    paddle_input_arbiter_if.slave bus
);
    localparam int TW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    logic [1:0]                  r_mode_q,     w_mode_q_nxt;
    logic [SW-1:0]               r_settle_cnt, w_settle_nxt;
    logic [PLAYERS-1:0]          r_up_k,       w_up_k_nxt;
    logic [PLAYERS-1:0]          r_dn_k,       w_dn_k_nxt;
    logic [PLAYERS-1:0][TW-1:0]  r_up_tmr,     w_up_tmr_nxt;
    logic [PLAYERS-1:0][TW-1:0]  r_dn_tmr,     w_dn_tmr_nxt;
    logic [PLAYERS-1:0]          r_paddle_up;
    logic [PLAYERS-1:0]          r_paddle_down;
    logic                        r_settling,   w_settling_nxt;
    logic [PLAYERS-1:0]          w_req_up;
    logic [PLAYERS-1:0]          w_req_dn;

    // Letters compare with bit 5 ignored so upper and lower case map to the same key.
    function automatic logic key_match(input logic [7:0] a, input logic [7:0] b);
        return (a & 8'hDF) == (b & 8'hDF);
    endfunction

    // Next-state of mode tracking, settle counter and key latches, plus the raw requests.
    always_comb begin
        w_mode_q_nxt   = r_mode_q;
        w_settle_nxt   = r_settle_cnt;
        w_up_k_nxt     = r_up_k;
        w_dn_k_nxt     = r_dn_k;
        w_up_tmr_nxt   = r_up_tmr;
        w_dn_tmr_nxt   = r_dn_tmr;
        w_settling_nxt = 1'b0;
        w_req_up       = '0;
        w_req_dn       = '0;

        if (bus.input_mode != r_mode_q) begin
            w_mode_q_nxt   = bus.input_mode;
            w_settle_nxt   = SW'(SETTLE_CYCLES);
            w_settling_nxt = 1'b1;
            w_up_k_nxt     = '0;
            w_dn_k_nxt     = '0;
            w_up_tmr_nxt   = '0;
            w_dn_tmr_nxt   = '0;
        end else if (r_settle_cnt != '0) begin
            // Blanking: bytes are dropped and latches are held clear.
            w_settle_nxt   = r_settle_cnt - SW'(1);
            w_settling_nxt = 1'b1;
            w_up_k_nxt     = '0;
            w_dn_k_nxt     = '0;
            w_up_tmr_nxt   = '0;
            w_dn_tmr_nxt   = '0;
        end else begin
            case (r_mode_q)
                2'd0: begin
                    for (int p = 0; p < PLAYERS; p++) begin
                        w_req_up[p] = ~bus.btn_n[2*p];
                        w_req_dn[p] = ~bus.btn_n[2*p+1];
                    end
                    w_up_k_nxt   = '0;
                    w_dn_k_nxt   = '0;
                    w_up_tmr_nxt = '0;
                    w_dn_tmr_nxt = '0;
                end
                2'd1: begin
                    // Age the timers first so a same-cycle reload below overrides expiry.
                    for (int p = 0; p < PLAYERS; p++) begin
                        if (r_up_tmr[p] != '0) begin
                            w_up_tmr_nxt[p] = r_up_tmr[p] - TW'(1);
                            if (r_up_tmr[p] == TW'(1)) w_up_k_nxt[p] = 1'b0;
                        end
                        if (r_dn_tmr[p] != '0) begin
                            w_dn_tmr_nxt[p] = r_dn_tmr[p] - TW'(1);
                            if (r_dn_tmr[p] == TW'(1)) w_dn_k_nxt[p] = 1'b0;
                        end
                    end
                    if (bus.rx_valid) begin
                        if (bus.rx_data == STOP_KEY) begin
                            w_up_k_nxt   = '0;
                            w_dn_k_nxt   = '0;
                            w_up_tmr_nxt = '0;
                            w_dn_tmr_nxt = '0;
                        end else begin
                            for (int p = 0; p < PLAYERS; p++) begin
                                if (key_match(bus.rx_data, KEY_MAP[16*p +: 8])) begin
                                    w_up_k_nxt[p]   = 1'b1;
                                    w_up_tmr_nxt[p] = TW'(HOLD_CYCLES);
                                    w_dn_k_nxt[p]   = 1'b0;
                                    w_dn_tmr_nxt[p] = '0;
                                end
                                if (key_match(bus.rx_data, KEY_MAP[16*p+8 +: 8])) begin
                                    w_dn_k_nxt[p]   = 1'b1;
                                    w_dn_tmr_nxt[p] = TW'(HOLD_CYCLES);
                                    w_up_k_nxt[p]   = 1'b0;
                                    w_up_tmr_nxt[p] = '0;
                                end
                            end
                        end
                    end
                    w_req_up = w_up_k_nxt;
                    w_req_dn = w_dn_k_nxt;
                end
                default: begin
                    w_up_k_nxt   = '0;
                    w_dn_k_nxt   = '0;
                    w_up_tmr_nxt = '0;
                    w_dn_tmr_nxt = '0;
                end
            endcase
        end
    end

    // State register; outputs are flops with opposing requests cancelled per player.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q      <= bus.input_mode;
            r_settle_cnt  <= SW'(SETTLE_CYCLES);
            r_up_k        <= '0;
            r_dn_k        <= '0;
            r_up_tmr      <= '0;
            r_dn_tmr      <= '0;
            r_paddle_up   <= '0;
            r_paddle_down <= '0;
            r_settling    <= 1'b1;
        end else begin
            r_mode_q      <= w_mode_q_nxt;
            r_settle_cnt  <= w_settle_nxt;
            r_up_k        <= w_up_k_nxt;
            r_dn_k        <= w_dn_k_nxt;
            r_up_tmr      <= w_up_tmr_nxt;
            r_dn_tmr      <= w_dn_tmr_nxt;
            r_paddle_up   <= w_req_up & ~w_req_dn;
            r_paddle_down <= w_req_dn & ~w_req_up;
            r_settling    <= w_settling_nxt;
        end
    end

    assign bus.paddle_up     = r_paddle_up;
    assign bus.paddle_down   = r_paddle_down;
    assign bus.mode_settling = r_settling;
endmodule

// File: tb/tb_paddle_input_arbiter.sv
// tb/tb_paddle_input_arbiter.sv - self-checking bench for paddle_input_arbiter
module tb_paddle_input_arbiter;
    localparam int S = 16;
    localparam int H = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    paddle_input_arbiter_if #(.PLAYERS(2)) dut_if ();

    paddle_input_arbiter #(
        .PLAYERS(2), .HOLD_CYCLES(H), .SETTLE_CYCLES(S),
        .KEY_MAP({"l", "o", "s", "w"}), .STOP_KEY(8'h20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dut_if)
    );

    int total = 0;
    int bad   = 0;

    // Model state: key direction per player (0 none, 1 up, 2 down) and last edge it is active.
    logic [7:0] keys [4] = '{"w", "s", "o", "l"};
    int         cyc = 0;
    logic       m_valid = 1'b0;
    logic [1:0] m_mode;
    int         m_active_from;
    int         m_dir  [2];
    int         m_last [2];
    logic [1:0] exp_up, exp_dn;
    logic       exp_set;

    // Behavioural model, evaluated from the inputs sampled at each rising edge.
    always @(posedge clk) begin
        logic [1:0] ru, rd;
        cyc++;
        ru = 2'b00;
        rd = 2'b00;
        if (rst || dut_if.input_mode != m_mode) begin
            m_mode        = dut_if.input_mode;
            m_active_from = cyc + S + 1;
            m_dir         = '{0, 0};
            exp_set       = 1'b1;
            m_valid       = 1'b1;
        end else if (cyc < m_active_from) begin
            m_dir   = '{0, 0};
            exp_set = 1'b1;
        end else begin
            exp_set = 1'b0;
            if (m_mode == 2'd0) begin
                for (int p = 0; p < 2; p++) begin
                    ru[p] = !dut_if.btn_n[2*p];
                    rd[p] = !dut_if.btn_n[2*p+1];
                end
                m_dir = '{0, 0};
            end else if (m_mode == 2'd1) begin
                if (dut_if.rx_valid) begin
                    if (dut_if.rx_data == 8'h20) m_dir = '{0, 0};
                    else begin
                        for (int p = 0; p < 2; p++)
                            for (int d = 0; d < 2; d++)
                                if ((dut_if.rx_data | 8'h20) == (keys[2*p+d] | 8'h20)) begin
                                    m_dir[p]  = d + 1;
                                    m_last[p] = cyc + H - 1;
                                end
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    ru[p] = (m_dir[p] == 1) && (cyc <= m_last[p]);
                    rd[p] = (m_dir[p] == 2) && (cyc <= m_last[p]);
                end
            end else begin
                m_dir = '{0, 0};
            end
        end
        exp_up = ru & ~rd;
        exp_dn = rd & ~ru;
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            total++;
            if ({dut_if.paddle_up, dut_if.paddle_down, dut_if.mode_settling} !== {exp_up, exp_dn, exp_set}) begin
                bad++;
                $display("FAIL cycle %0d: got up=%b dn=%b set=%b, want up=%b dn=%b set=%b",
                         cyc, dut_if.paddle_up, dut_if.paddle_down, dut_if.mode_settling,
                         exp_up, exp_dn, exp_set);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        dut_if.rx_data  = b;
        dut_if.rx_valid = 1'b1;
        @(negedge clk);
        dut_if.rx_valid = 1'b0;
    endtask

    // Hand-computed expectation, checked against both the DUT and the model.
    task automatic lit(input string name, input logic [1:0] up, input logic [1:0] dn, input logic st);
        total++;
        if ({dut_if.paddle_up, dut_if.paddle_down, dut_if.mode_settling} !== {up, dn, st}) begin
            bad++;
            $display("FAIL %s: got up=%b dn=%b set=%b, want up=%b dn=%b set=%b", name,
                     dut_if.paddle_up, dut_if.paddle_down, dut_if.mode_settling, up, dn, st);
        end
        total++;
        if ({exp_up, exp_dn, exp_set} !== {up, dn, st}) begin
            bad++;
            $display("FAIL model_%s: got up=%b dn=%b set=%b, want up=%b dn=%b set=%b", name,
                     exp_up, exp_dn, exp_set, up, dn, st);
        end
    endtask

    initial begin
        dut_if.input_mode = 2'd0;
        dut_if.btn_n      = 4'b1111;
        dut_if.rx_data    = 8'h00;
        dut_if.rx_valid   = 1'b0;
        tick(2);
        lit("reset", 2'b00, 2'b00, 1'b1);

        rst = 1'b0;
        dut_if.btn_n = 4'b1110;
        tick(S);
        lit("btn_settle_last", 2'b00, 2'b00, 1'b1);
        tick(1);
        lit("btn_p0_up", 2'b01, 2'b00, 1'b0);
        dut_if.btn_n = 4'b1100;
        tick(1);
        lit("btn_conflict", 2'b00, 2'b00, 1'b0);
        dut_if.btn_n = 4'b0111;
        tick(1);
        lit("btn_p1_down", 2'b00, 2'b10, 1'b0);

        dut_if.input_mode = 2'd1;
        tick(S + 1);
        lit("kb_settle_last", 2'b00, 2'b00, 1'b1);
        tick(1);
        lit("kb_settled", 2'b00, 2'b00, 1'b0);

        send("w");
        lit("hold_start", 2'b01, 2'b00, 1'b0);
        tick(H - 1);
        lit("hold_last", 2'b01, 2'b00, 1'b0);
        tick(1);
        lit("hold_expired", 2'b00, 2'b00, 1'b0);

        send("w");
        tick(49);
        send("W");
        tick(H - 1);
        lit("ext_last", 2'b01, 2'b00, 1'b0);
        tick(1);
        lit("ext_expired", 2'b00, 2'b00, 1'b0);

        send("w");
        tick(9);
        send("s");
        lit("last_key_wins", 2'b00, 2'b01, 1'b0);
        send("o");
        lit("two_players", 2'b10, 2'b01, 1'b0);
        send(8'h20);
        lit("stop_key", 2'b00, 2'b00, 1'b0);

        send("o");
        tick(H - 1);
        lit("collide_before", 2'b10, 2'b00, 1'b0);
        send("o");
        lit("collide_reload", 2'b10, 2'b00, 1'b0);
        send("x");
        lit("unmatched", 2'b10, 2'b00, 1'b0);
        send("L");
        lit("upper_case_down", 2'b00, 2'b10, 1'b0);
        send("w");
        lit("both_latched", 2'b01, 2'b10, 1'b0);

        dut_if.input_mode = 2'd0;
        tick(1);
        lit("mode_change_blank", 2'b00, 2'b00, 1'b1);
        tick(5);
        dut_if.input_mode = 2'd1;
        tick(1);
        send("w");
        tick(S - 1);
        lit("restart_settle", 2'b00, 2'b00, 1'b1);
        tick(1);
        lit("settle_drops_bytes", 2'b00, 2'b00, 1'b0);

        send("w");
        tick(10);
        rst = 1'b1;
        tick(1);
        lit("reset_mid_hold", 2'b00, 2'b00, 1'b1);
        rst = 1'b0;
        tick(S);
        lit("reset_settle_last", 2'b00, 2'b00, 1'b1);
        tick(1);
        lit("no_stale_latch", 2'b00, 2'b00, 1'b0);

        dut_if.btn_n = 4'b0000;
        dut_if.input_mode = 2'd2;
        tick(S + 2);
        lit("mode2_quiet", 2'b00, 2'b00, 1'b0);
        send("w");
        lit("mode2_byte", 2'b00, 2'b00, 1'b0);
        dut_if.input_mode = 2'd3;
        tick(S + 2);
        lit("mode3_quiet", 2'b00, 2'b00, 1'b0);

        dut_if.input_mode = 2'd0;
        tick(S + 2);
        lit("btn_all_conflict", 2'b00, 2'b00, 1'b0);
        dut_if.btn_n = 4'b1010;
        tick(1);
        lit("btn_both_up", 2'b11, 2'b00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
